// File: rtl/rv_mem_arb.sv
// rv_mem_arb: two-requester (core, debug) arbiter in front of a single-ported memory.
// Round-robin grant on contention, per-access timeout, one-cycle done pulse per owner.
module rv_mem_arb #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,

  // Core requester
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_done_o,
  output logic          core_err_o,
  output logic [DW-1:0] core_rdata_o,

  // Debug requester
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_done_o,
  output logic          dbg_err_o,
  output logic [DW-1:0] dbg_rdata_o,

  // Memory side
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,

  output logic          busy_o
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef enum logic {
    OwnCore,
    OwnDbg
  } owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  // Last requester granted; drives round-robin on contention.
  owner_e          last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [DW-1:0]   core_rdata_q, core_rdata_d;
  logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;

  logic            grant_core;
  logic            grant_dbg;
  logic [DW-1:0]   ack_data;

  // Round-robin arbitration: core wins a tie only if debug was granted last.
  always_comb begin
    grant_core = core_req_i & (~dbg_req_i | (last_q == OwnDbg));
    grant_dbg  = dbg_req_i & ~grant_core;
  end

  // Data to capture on ack: writes return zero.
  always_comb begin
    ack_data = we_q ? '0 : mem_rdata_i;
  end

  // Next-state logic for the access FSM and its data registers.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_core) begin
          state_d = StBusy;
          owner_d = OwnCore;
          last_d  = OwnCore;
          cnt_d   = '0;
          we_d    = core_we_i;
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
        end else if (grant_dbg) begin
          state_d = StBusy;
          owner_d = OwnDbg;
          last_d  = OwnDbg;
          cnt_d   = '0;
          we_d    = dbg_we_i;
          addr_d  = dbg_addr_i;
          wdata_d = dbg_wdata_i;
        end
      end

      StBusy: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          state_d = StDone;
          err_d   = 1'b0;
          if (owner_q == OwnCore) begin
            core_rdata_d = ack_data;
          end else begin
            dbg_rdata_d = ack_data;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (owner_q == OwnCore) begin
            core_rdata_d = '0;
          end else begin
            dbg_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        // No grant here: a still-held request is seen again in the next idle cycle.
        state_d = StIdle;
        cnt_d   = '0;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      owner_q      <= OwnCore;
      last_q       <= OwnDbg;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Outputs: memory fields come only from the latches and read as zero outside BUSY.
  always_comb begin
    busy_o       = (state_q != StIdle);
    mem_req_o    = (state_q == StBusy);
    mem_we_o     = mem_req_o & we_q;
    mem_addr_o   = mem_req_o ? addr_q : '0;
    mem_wdata_o  = mem_req_o ? wdata_q : '0;
    core_done_o  = (state_q == StDone) && (owner_q == OwnCore);
    dbg_done_o   = (state_q == StDone) && (owner_q == OwnDbg);
    core_err_o   = core_done_o & err_q;
    dbg_err_o    = dbg_done_o & err_q;
    core_rdata_o = core_rdata_q;
    dbg_rdata_o  = dbg_rdata_q;
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: directed scenarios with literal expectations, then randomized traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_rv_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_req = 0, core_we = 0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_done, core_err;
  logic [DW-1:0] core_rdata;
  logic          dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_done, dbg_err;
  logic [DW-1:0] dbg_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 0;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  rv_mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_done_o(core_done), .core_err_o(core_err),
    .core_rdata_o(core_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_done_o(dbg_done), .dbg_err_o(dbg_err),
    .dbg_rdata_o(dbg_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one access at a time, described as a transaction.
  // phase 0 = idle, 1 = access outstanding, 2 = result being reported.
  int          m_phase = 0;
  int          m_owner = 0;   // 0 core, 1 dbg
  int          m_last  = 1;
  int          m_age   = 0;   // cycles the access has been outstanding
  bit          m_we    = 0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  bit          m_err   = 0;
  logic [31:0] m_rd[2] = '{default: '0};

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_age = 0; m_last = 1; m_err = 0;
      m_rd[0] = '0; m_rd[1] = '0;
    end else if (m_phase == 0) begin
      int pick;
      pick = -1;
      if (core_req && dbg_req) pick = 1 - m_last;
      else if (core_req)       pick = 0;
      else if (dbg_req)        pick = 1;
      if (pick >= 0) begin
        m_owner = pick; m_last = pick; m_phase = 1; m_age = 0;
        m_we    = (pick == 0) ? core_we    : dbg_we;
        m_addr  = (pick == 0) ? core_addr  : dbg_addr;
        m_wdata = (pick == 0) ? core_wdata : dbg_wdata;
      end
    end else if (m_phase == 1) begin
      m_age++;
      if (mem_ack) begin
        m_rd[m_owner] = m_we ? 32'h0 : mem_rdata;
        m_err = 0; m_phase = 2;
      end else if (m_age == TO) begin
        m_rd[m_owner] = 32'h0;
        m_err = 1; m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit act, rep_c, rep_d;
      act   = (m_phase == 1);
      rep_c = (m_phase == 2) && (m_owner == 0);
      rep_d = (m_phase == 2) && (m_owner == 1);
      check("busy",       busy,       m_phase != 0);
      check("mem_req",    mem_req,    act);
      check("mem_we",     mem_we,     act && m_we);
      check("mem_addr",   mem_addr,   act ? m_addr : 32'h0);
      check("mem_wdata",  mem_wdata,  act ? m_wdata : 32'h0);
      check("core_done",  core_done,  rep_c);
      check("core_err",   core_err,   rep_c && m_err);
      check("core_rdata", core_rdata, m_rd[0]);
      check("dbg_done",   dbg_done,   rep_d);
      check("dbg_err",    dbg_err,    rep_d && m_err);
      check("dbg_rdata",  dbg_rdata,  m_rd[1]);
    end
  end

  initial begin
    int n;
    rst = 1;
    tick(); tick();
    chk_en = 1;
    rst = 0;

    // Core read with ack on 3rd busy cycle; address change mid-access ignored.
    core_req = 1; core_we = 0; core_addr = 32'h100; core_wdata = 32'h0;
    tick();
    @(negedge clk);
    check("t41_req_c1",  mem_req,  1);
    check("t41_addr_c1", mem_addr, 32'h100);
    tick();
    core_addr = 32'h200;
    @(negedge clk);
    check("t45_addr_c2", mem_addr, 32'h100);
    tick();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t45_addr_c3", mem_addr, 32'h100);
    tick();
    mem_ack = 0; core_req = 0;
    @(negedge clk);
    check("t41_done",  core_done,  1);
    check("t41_rdata", core_rdata, 32'hDEADBEEF);
    check("t41_err",   core_err,   0);
    check("t45_addr_done", mem_addr, 32'h0);
    tick();
    @(negedge clk);
    check("t41_idle", busy, 0);

    // Contention after reset: core first, then dbg, then core again.
    rst = 1; tick(); rst = 0;
    core_req = 1; core_addr = 32'hA0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'hB0;
    tick();
    @(negedge clk);
    check("t42_first", mem_addr, 32'hA0);
    mem_ack = 1; tick(); mem_ack = 0; core_req = 0;
    @(negedge clk);
    check("t42_cdone", core_done, 1);
    tick();
    core_req = 1; core_addr = 32'hA4;
    @(negedge clk);
    check("t42_idle", busy, 0);
    tick();
    @(negedge clk);
    check("t42_second", mem_addr, 32'hB0);
    mem_ack = 1; tick(); mem_ack = 0; dbg_req = 0;
    @(negedge clk);
    check("t42_ddone", dbg_done, 1);
    check("t42_drdata", dbg_rdata, 32'hDEADBEEF);
    tick(); tick();
    @(negedge clk);
    check("t42_third", mem_addr, 32'hA4);
    mem_ack = 1; tick(); mem_ack = 0; core_req = 0;
    tick();

    // Debug write with no ack: times out after TO busy cycles.
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h55;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      if (n == 0) begin
        check("t43_we",    mem_we,    1);
        check("t43_wdata", mem_wdata, 32'h55);
      end
      n++;
      tick();
    end
    dbg_req = 0;
    check("t43_cycles", n, 15);
    check("t43_done",   dbg_done,  1);
    check("t43_err",    dbg_err,   1);
    check("t43_rdata",  dbg_rdata, 32'h0);
    tick();

    // Ack on the final timeout cycle wins.
    core_req = 1; core_we = 0; core_addr = 32'h300;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 0; core_req = 0;
    @(negedge clk);
    check("t44_done",  core_done,  1);
    check("t44_err",   core_err,   0);
    check("t44_rdata", core_rdata, 32'h12345678);
    tick();

    // Reset during busy, late ack ignored.
    core_req = 1; core_addr = 32'h40;
    tick();
    rst = 1;
    tick();
    rst = 0; mem_ack = 1; core_req = 0;
    @(negedge clk);
    check("t46_busy",  busy,       0);
    check("t46_req",   mem_req,    0);
    check("t46_rdata", core_rdata, 32'h0);
    tick();
    mem_ack = 0;
    @(negedge clk);
    check("t46_done", core_done, 0);
    check("t46_idle", busy,      0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst       = ($urandom % 250 == 0);
      mem_ack   = ($urandom % 10 == 0);
      mem_rdata = $urandom;
      if (core_req) begin
        if (rst || (core_done && ($urandom % 4 != 0))) core_req = 0;
        else if ($urandom % 3 == 0) begin
          core_addr = $urandom; core_wdata = $urandom; core_we = $urandom % 2;
        end
      end else if ($urandom % 3 == 0) begin
        core_req = 1; core_addr = $urandom; core_wdata = $urandom; core_we = $urandom % 2;
      end
      if (dbg_req) begin
        if (rst || (dbg_done && ($urandom % 4 != 0))) dbg_req = 0;
        else if ($urandom % 3 == 0) begin
          dbg_addr = $urandom; dbg_wdata = $urandom; dbg_we = $urandom % 2;
        end
      end else if ($urandom % 3 == 0) begin
        dbg_req = 1; dbg_addr = $urandom; dbg_wdata = $urandom; dbg_we = $urandom % 2;
      end
    end
    rst = 0; core_req = 0; dbg_req = 0; mem_ack = 0;
    tick(); tick();
    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mem_arb.md
RV_MEM_ARB -- requirements
Module: rv_mem_arb

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits.
REQ-003 Parameter TIMEOUT, 15, maximum BUSY cycles without mem_ack; range 1..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 core_req  in  1  core (fetch/load/store) access request; held until core_done.
REQ-007 core_we  in  1  1=write, 0=read.
REQ-008 core_addr  in  AW  core address.
REQ-009 core_wdata  in  DW  core write data.
REQ-010 core_done  out  1  one-cycle completion pulse to core.
REQ-011 core_err  out  1  timeout flag; valid only with core_done.
REQ-012 core_rdata  out  DW  read data; valid only with core_done.
REQ-013 dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug port request; same meaning as the core_* inputs.
REQ-014 dbg_done, dbg_err, dbg_rdata  out  1/1/DW  debug port response; same meaning as the core_* outputs.
REQ-015 mem_req  out  1  memory access strobe.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  AW  memory address.
REQ-018 mem_wdata  out  DW  memory write data.
REQ-019 mem_rdata  in  DW  memory read data; valid with mem_ack.
REQ-020 mem_ack  in  1  memory completion, one cycle.
REQ-021 busy  out  1  state is not IDLE.

Function
REQ-022 FSM states: IDLE, BUSY, DONE; owner register selects CORE or DBG.
REQ-023 IDLE, no request pending: stay in IDLE.
REQ-024 IDLE, exactly one request pending: grant that requester and go to BUSY.
REQ-025 IDLE, both requests pending: grant the requester that was not granted last (round-robin), then go to BUSY.
REQ-026 On grant, latch the granted we/addr/wdata; mem_we/mem_addr/mem_wdata come from the latches only.
REQ-027 Later changes on requester inputs have no effect on the access in flight.
REQ-028 BUSY: mem_req=1, and the timeout counter increments each cycle starting from 0.
REQ-029 BUSY with mem_ack=1: capture mem_rdata into the owner's rdata register (reads only; writes capture 0), clear err, go to DONE.
REQ-030 BUSY with counter==TIMEOUT-1 and mem_ack=0: rdata=0, err=1, go to DONE.
REQ-031 mem_ack and timeout in the same cycle: ack wins, err=0.
REQ-032 DONE: owner's done=1 for exactly one cycle with its err and rdata; mem_req=0; go to IDLE; no grant is issued in DONE.
REQ-033 A request still held in the IDLE cycle after done is treated as a new request.
REQ-034 mem_ack outside BUSY is ignored.
REQ-035 Latency: req seen in IDLE at cycle 0 -> mem_req at cycle 1; ack at cycle k -> done at k+1 -> IDLE at k+2.
REQ-036 The non-owner's done/err stay 0; its rdata holds its last value.
REQ-037 mem_we/mem_addr/mem_wdata are 0 whenever mem_req=0.

Reset
REQ-038 rst=1 forces IDLE, counter=0, all done/err/rdata/mem_* outputs 0 and busy=0 on the next edge.
REQ-039 After reset, last-granted = DBG, so the core wins the first contention.
REQ-040 rst during BUSY or DONE aborts the access with no done pulse; a late mem_ack after reset is ignored.

Verification
REQ-041 Core read 0x100, mem_ack on 3rd BUSY cycle, mem_rdata=0xDEADBEEF -> core_done at cycle 4 with rdata 0xDEADBEEF, err=0.
REQ-042 Core and dbg request together right after reset -> core granted first; dbg granted in the IDLE after core_done; core re-requests and is granted after dbg.
REQ-043 Dbg write 0x20=0x55, no mem_ack -> mem_req high 15 cycles, then dbg_done=1, dbg_err=1, dbg_rdata=0.
REQ-044 mem_ack coincides with the final timeout cycle -> done with err=0 and captured data.
REQ-045 Core changes core_addr from 0x100 to 0x200 mid-BUSY -> mem_addr stays 0x100 until DONE.
REQ-046 rst asserted in BUSY, mem_ack next cycle -> no done pulse, state IDLE, all outputs 0.
